// File: rtl/dcache_wb_if.sv
// Bundle of the writeback engine's ctrl, data/dirty array and AXI write-channel signals.
// The engine uses the master view; the surrounding environment uses the slave view.
interface dcache_wb_if;
  logic         ctrl2wb_valid;
  logic [5:0]   ctrl2wb_index;
  logic [2:0]   ctrl2wb_way;
  logic [43:0]  ctrl2wb_tag;
  logic         wb2ctrl_ready;
  logic         wb2ctrl_err;
  logic         wb2data_array_valid;
  logic [5:0]   wb2data_array_index;
  logic [2:0]   wb2data_array_way;
  logic [1:0]   wb2data_array_offset;
  logic [127:0] data_array2wb_rdata;
  logic         wb2dirty_array_valid;
  logic [5:0]   wb2dirty_array_index;
  logic [2:0]   wb2dirty_array_way;
  logic         awvalid;
  logic         awready;
  logic [63:0]  awaddr;
  logic [3:0]   awid;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         wvalid;
  logic         wready;
  logic [127:0] wdata;
  logic [15:0]  wstrb;
  logic         wlast;
  logic         bvalid;
  logic         bready;
  logic [1:0]   bresp;
  logic [3:0]   bid;

  modport master (
    input  ctrl2wb_valid, ctrl2wb_index, ctrl2wb_way, ctrl2wb_tag,
    output wb2ctrl_ready, wb2ctrl_err,
    output wb2data_array_valid, wb2data_array_index, wb2data_array_way, wb2data_array_offset,
    input  data_array2wb_rdata,
    output wb2dirty_array_valid, wb2dirty_array_index, wb2dirty_array_way,
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp, bid,
    output bready
  );

  modport slave (
    output ctrl2wb_valid, ctrl2wb_index, ctrl2wb_way, ctrl2wb_tag,
    input  wb2ctrl_ready, wb2ctrl_err,
    input  wb2data_array_valid, wb2data_array_index, wb2data_array_way, wb2data_array_offset,
    output data_array2wb_rdata,
    input  wb2dirty_array_valid, wb2dirty_array_index, wb2dirty_array_way,
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp, bid,
    input  bready
  );
endinterface

// File: rtl/dcache_wb.sv
// Dirty-victim writeback engine: reads a 64-byte line into a local buffer, writes it as one
// 4-beat AXI INCR burst, then clears the dirty bit (unless the slave reported an error).
module dcache_wb #(
  parameter logic [3:0] AXI_ID = 4'b0010
) (
  input logic        clock,
  input logic        reset,
  dcache_wb_if.master bus
);

  typedef enum logic [2:0] {IDLE, RD, AW, W, B} state_t;

  state_t       state;
  logic [2:0]   rd_cnt;
  logic [1:0]   wr_cnt;
  logic [5:0]   index_r;
  logic [2:0]   way_r;
  logic [43:0]  tag_r;
  logic [127:0] line_buf [4];

  logic         rd_valid_r;
  logic [1:0]   offset_r;
  logic         dirty_valid_r;
  logic         ready_r;
  logic         err_r;
  logic         awvalid_r;
  logic         wvalid_r;
  logic [127:0] wdata_r;
  logic         wlast_r;
  logic         bready_r;

  // Every handshake output is a register loaded with the value for the state being entered.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= IDLE;
      rd_cnt        <= 3'd0;
      wr_cnt        <= 2'd0;
      index_r       <= 6'd0;
      way_r         <= 3'd0;
      tag_r         <= 44'd0;
      rd_valid_r    <= 1'b0;
      offset_r      <= 2'd0;
      dirty_valid_r <= 1'b0;
      ready_r       <= 1'b0;
      err_r         <= 1'b0;
      awvalid_r     <= 1'b0;
      wvalid_r      <= 1'b0;
      wdata_r       <= 128'd0;
      wlast_r       <= 1'b0;
      bready_r      <= 1'b0;
    end else begin
      dirty_valid_r <= 1'b0;
      ready_r       <= 1'b0;
      err_r         <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.ctrl2wb_valid) begin
            index_r    <= bus.ctrl2wb_index;
            way_r      <= bus.ctrl2wb_way;
            tag_r      <= bus.ctrl2wb_tag;
            rd_cnt     <= 3'd0;
            rd_valid_r <= 1'b1;
            offset_r   <= 2'd0;
            state      <= RD;
          end
        end
        RD: begin
          // Array data lags its request by one cycle, so beat rd_cnt-1 lands now.
          if (rd_cnt != 3'd0) begin
            line_buf[rd_cnt[1:0] - 2'd1] <= bus.data_array2wb_rdata;
          end
          if (rd_cnt == 3'd4) begin
            awvalid_r <= 1'b1;
            state     <= AW;
          end else begin
            rd_cnt     <= rd_cnt + 3'd1;
            rd_valid_r <= (rd_cnt < 3'd3);
            offset_r   <= rd_cnt[1:0] + 2'd1;
          end
        end
        AW: begin
          if (bus.awready) begin
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b1;
            wr_cnt    <= 2'd0;
            wdata_r   <= line_buf[0];
            wlast_r   <= 1'b0;
            state     <= W;
          end
        end
        W: begin
          if (bus.wready) begin
            if (wr_cnt == 2'd3) begin
              wvalid_r <= 1'b0;
              wlast_r  <= 1'b0;
              bready_r <= 1'b1;
              state    <= B;
            end else begin
              wr_cnt  <= wr_cnt + 2'd1;
              wdata_r <= line_buf[wr_cnt + 2'd1];
              wlast_r <= (wr_cnt == 2'd2);
            end
          end
        end
        B: begin
          // Responses for other IDs belong to someone else; keep waiting.
          if (bus.bvalid && (bus.bid == AXI_ID)) begin
            bready_r      <= 1'b0;
            ready_r       <= 1'b1;
            err_r         <= bus.bresp[1];
            dirty_valid_r <= ~bus.bresp[1];
            state         <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.wb2ctrl_ready        = ready_r;
  assign bus.wb2ctrl_err          = err_r;
  assign bus.wb2data_array_valid  = rd_valid_r;
  assign bus.wb2data_array_index  = index_r;
  assign bus.wb2data_array_way    = way_r;
  assign bus.wb2data_array_offset = offset_r;
  assign bus.wb2dirty_array_valid = dirty_valid_r;
  assign bus.wb2dirty_array_index = index_r;
  assign bus.wb2dirty_array_way   = way_r;
  assign bus.awvalid              = awvalid_r;
  assign bus.awaddr               = {8'h00, tag_r, index_r, 6'h00};
  assign bus.awid                 = AXI_ID;
  assign bus.awlen                = 8'd3;
  assign bus.awsize               = 3'b100;
  assign bus.awburst              = 2'b01;
  assign bus.wvalid               = wvalid_r;
  assign bus.wdata                = wdata_r;
  assign bus.wstrb                = 16'hFFFF;
  assign bus.wlast                = wlast_r;
  assign bus.bready               = bready_r;

endmodule

// File: tb/tb_dcache_wb.sv
// Randomized bench for dcache_wb: array/AXI responders, a negedge monitor and a
// transaction-level model of what each writeback must put on the bus.
module tb_dcache_wb;
  localparam logic [3:0] AXI_ID = 4'b0010;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  dcache_wb_if bus();
  dcache_wb dut (.clock(clock), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Scenario knobs (written by the stimulus only)
  bit           stall_en = 1'b0;
  bit           foreign_en = 1'b0;
  logic [1:0]   resp_code = 2'b00;
  logic [127:0] line_base = 128'd0;
  logic [5:0]   exp_idx = 6'd0;
  logic [2:0]   exp_way = 3'd0;

  // Monitor records (written by the monitor only)
  int aw_cnt = 0, rdy_cnt = 0, dirty_cnt = 0, rdy_cyc = 0, dirty_cyc = 0;
  int stab_err = 0, aw_after_err = 0, b_err = 0, rd_bad = 0;
  logic [63:0] rec_awaddr;
  logic [7:0]  rec_awlen;
  logic [2:0]  rec_awsize;
  logic [1:0]  rec_awburst;
  logic [3:0]  rec_awid;
  logic [15:0] rec_wstrb;
  logic        rec_err;
  logic [5:0]  rec_dirty_idx;
  logic [2:0]  rec_dirty_way;
  logic [127:0] w_q[$];
  logic         wl_q[$];
  bit rd_pend = 1'b0;
  logic [1:0] rd_off = 2'd0;
  bit prev_aw_stall = 1'b0, prev_aw_hs = 1'b0, prev_w_stall = 1'b0, prev_foreign = 1'b0;
  logic [63:0]  prev_awaddr;
  logic [127:0] prev_wdata;
  logic         prev_wlast;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Monitor: sample everything mid-cycle, record handshakes and protocol violations
  always @(negedge clock) begin
    rd_pend = bus.wb2data_array_valid && reset;
    rd_off  = bus.wb2data_array_offset;
    if (reset) begin
      if (bus.wb2data_array_valid && (bus.wb2data_array_index != exp_idx || bus.wb2data_array_way != exp_way))
        rd_bad++;
      if (prev_aw_stall && (!bus.awvalid || bus.awaddr != prev_awaddr)) stab_err++;
      if (prev_w_stall && (!bus.wvalid || bus.wdata != prev_wdata || bus.wlast != prev_wlast)) stab_err++;
      if (prev_aw_hs && bus.awvalid) aw_after_err++;
      if (prev_foreign && bus.wb2ctrl_ready) b_err++;
      if (bus.bvalid && bus.bid != AXI_ID && !bus.bready) b_err++;
      if (bus.awvalid && bus.awready) begin
        aw_cnt++;
        rec_awaddr = bus.awaddr; rec_awlen = bus.awlen; rec_awsize = bus.awsize;
        rec_awburst = bus.awburst; rec_awid = bus.awid;
      end
      if (bus.wvalid && bus.wready) begin
        w_q.push_back(bus.wdata);
        wl_q.push_back(bus.wlast);
        rec_wstrb = bus.wstrb;
      end
      if (bus.wb2dirty_array_valid) begin
        dirty_cnt++; dirty_cyc = cyc;
        rec_dirty_idx = bus.wb2dirty_array_index; rec_dirty_way = bus.wb2dirty_array_way;
      end
      if (bus.wb2ctrl_ready) begin
        rdy_cnt++; rdy_cyc = cyc; rec_err = bus.wb2ctrl_err;
      end
      prev_aw_stall = bus.awvalid && !bus.awready;
      prev_aw_hs    = bus.awvalid && bus.awready;
      prev_w_stall  = bus.wvalid && !bus.wready;
      prev_foreign  = bus.bvalid && bus.bid != AXI_ID;
      prev_awaddr   = bus.awaddr;
      prev_wdata    = bus.wdata;
      prev_wlast    = bus.wlast;
    end else begin
      prev_aw_stall = 1'b0; prev_aw_hs = 1'b0; prev_w_stall = 1'b0; prev_foreign = 1'b0;
    end
  end

  // Responders: data array (1-cycle read latency) and AXI slave with optional stalls
  initial begin
    int b_phase;
    int b_delay;
    bit foreign_pending;
    bit b_ok_prev;
    b_phase = 0; b_delay = 0; foreign_pending = 1'b0; b_ok_prev = 1'b0;
    bus.data_array2wb_rdata = 128'd0;
    bus.awready = 1'b0; bus.wready = 1'b0;
    bus.bvalid = 1'b0; bus.bid = 4'd0; bus.bresp = 2'b00;
    forever begin
      @(posedge clock); #1;
      bus.data_array2wb_rdata = rd_pend ? line_base + {126'd0, rd_off}
                                        : {$urandom(), $urandom(), $urandom(), $urandom()};
      bus.awready = stall_en ? ($urandom_range(0, 2) == 0) : 1'b1;
      bus.wready  = stall_en ? ($urandom_range(0, 2) == 0) : 1'b1;
      if (b_ok_prev) begin
        bus.bvalid = 1'b0; b_phase = 0; b_ok_prev = 1'b0;
      end
      if (b_phase == 0 && bus.bready && reset) begin
        b_phase = 1;
        b_delay = stall_en ? int'($urandom_range(0, 3)) : 0;
        foreign_pending = foreign_en;
      end
      if (b_phase == 1) begin
        if (b_delay > 0) begin
          bus.bvalid = 1'b0; b_delay--;
        end else if (foreign_pending) begin
          bus.bvalid = 1'b1; bus.bid = 4'b0001; bus.bresp = 2'b00; foreign_pending = 1'b0;
        end else begin
          bus.bvalid = 1'b1; bus.bid = AXI_ID; bus.bresp = resp_code; b_ok_prev = 1'b1;
        end
      end else begin
        bus.bvalid = 1'b0;
      end
    end
  end

  task automatic randomize_ctrl_fields(input bit with_valid);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    bus.ctrl2wb_index = r[5:0];
    bus.ctrl2wb_way   = r[8:6];
    bus.ctrl2wb_tag   = r[63:20];
    bus.ctrl2wb_valid = with_valid ? r[9] : 1'b0;
  endtask

  task automatic run_wb(input logic [5:0] idx, input logic [2:0] way, input logic [43:0] tag,
                        input logic [127:0] base, input logic [1:0] resp,
                        input bit stall, input bit foreign, input bit toggle);
    int aw0, rd0, dt0, st0, af0, b0, rb0, w0, acc;
    bit timed_out;
    logic [63:0] exp_addr;
    aw0 = aw_cnt; rd0 = rdy_cnt; dt0 = dirty_cnt; st0 = stab_err; af0 = aw_after_err;
    b0 = b_err; rb0 = rd_bad; w0 = w_q.size();
    exp_addr = {8'h00, tag, idx, 6'h00};
    stall_en = stall; foreign_en = foreign; resp_code = resp; line_base = base;
    exp_idx = idx; exp_way = way;
    @(posedge clock); #1;
    bus.ctrl2wb_valid = 1'b1; bus.ctrl2wb_index = idx; bus.ctrl2wb_way = way; bus.ctrl2wb_tag = tag;
    @(posedge clock); #1;
    acc = cyc;
    if (toggle) begin
      repeat (9) begin
        randomize_ctrl_fields(1'b1);
        @(posedge clock); #1;
      end
    end
    randomize_ctrl_fields(1'b0);
    timed_out = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (rdy_cnt != rd0) begin timed_out = 1'b0; break; end
    end
    check_eq("completion_timeout", timed_out, 1'b0);
    repeat (4) @(negedge clock);
    check_eq("aw_count", aw_cnt - aw0, 1);
    check_eq("awaddr", rec_awaddr, exp_addr);
    check_eq("awlen", rec_awlen, 8'd3);
    check_eq("awsize", rec_awsize, 3'b100);
    check_eq("awburst", rec_awburst, 2'b01);
    check_eq("awid", rec_awid, AXI_ID);
    check_eq("wstrb", rec_wstrb, 16'hFFFF);
    check_eq("w_beats", w_q.size() - w0, 4);
    for (int k = 0; k < 4; k++) begin
      check_eq("wdata", (w0 + k < w_q.size()) ? w_q[w0 + k] : 128'hx, base + 128'(k));
      check_eq("wlast", (w0 + k < wl_q.size()) ? wl_q[w0 + k] : 1'bx, (k == 3));
    end
    check_eq("ready_pulses", rdy_cnt - rd0, 1);
    check_eq("ctrl_err", rec_err, resp[1]);
    check_eq("dirty_pulses", dirty_cnt - dt0, resp[1] ? 0 : 1);
    if (!resp[1]) begin
      check_eq("dirty_index", rec_dirty_idx, idx);
      check_eq("dirty_way", rec_dirty_way, way);
      check_eq("dirty_with_ready", dirty_cyc, rdy_cyc);
    end
    if (!stall && !foreign) check_eq("ready_latency", rdy_cyc - acc, 11);
    check_eq("stall_stability", stab_err - st0, 0);
    check_eq("awvalid_after_hs", aw_after_err - af0, 0);
    check_eq("foreign_bid", b_err - b0, 0);
    check_eq("array_rd_fields", rd_bad - rb0, 0);
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_awvalid"}, bus.awvalid, 1'b0);
    check_eq({tag, "_wvalid"}, bus.wvalid, 1'b0);
    check_eq({tag, "_bready"}, bus.bready, 1'b0);
    check_eq({tag, "_ready"}, bus.wb2ctrl_ready, 1'b0);
    check_eq({tag, "_err"}, bus.wb2ctrl_err, 1'b0);
    check_eq({tag, "_dirty"}, bus.wb2dirty_array_valid, 1'b0);
    check_eq({tag, "_rdvalid"}, bus.wb2data_array_valid, 1'b0);
  endtask

  initial begin
    logic [63:0] r;
    logic [127:0] base;
    int w0, rd0, dt0;
    bit timed_out;
    reset = 1'b0;
    bus.ctrl2wb_valid = 1'b0; bus.ctrl2wb_index = 6'd0; bus.ctrl2wb_way = 3'd0; bus.ctrl2wb_tag = 44'd0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_quiet("reset");
    @(posedge clock); #1;
    reset = 1'b1;

    run_wb(6'h15, 3'd5, 44'hABC, 128'd0, 2'b00, 1'b0, 1'b0, 1'b0);

    for (int t = 0; t < 4; t++) begin
      r = {$urandom(), $urandom()};
      base = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_wb(r[5:0], r[8:6], r[63:20], base, 2'(t % 2), 1'b1, 1'b0, 1'b0);
    end

    run_wb(6'h2A, 3'd1, 44'h123_4567_89AB, 128'h55, 2'b10, 1'b0, 1'b0, 1'b0);
    run_wb(6'h01, 3'd7, 44'hFFF_FFFF_FFFF, 128'hA0, 2'b11, 1'b1, 1'b0, 1'b0);
    run_wb(6'h3F, 3'd2, 44'h000_0000_0001, 128'h77, 2'b00, 1'b0, 1'b1, 1'b0);
    run_wb(6'h0C, 3'd6, 44'h8_0000_0000, 128'h1000, 2'b00, 1'b0, 1'b0, 1'b1);

    // Reset while the third W beat is pending
    stall_en = 1'b0; foreign_en = 1'b0; resp_code = 2'b00; line_base = 128'h40;
    exp_idx = 6'h09; exp_way = 3'd3;
    w0 = w_q.size(); rd0 = rdy_cnt; dt0 = dirty_cnt;
    @(posedge clock); #1;
    bus.ctrl2wb_valid = 1'b1; bus.ctrl2wb_index = 6'h09; bus.ctrl2wb_way = 3'd3; bus.ctrl2wb_tag = 44'h5A5;
    @(posedge clock); #1;
    bus.ctrl2wb_valid = 1'b0;
    timed_out = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (w_q.size() - w0 >= 2) begin timed_out = 1'b0; break; end
    end
    check_eq("reach_w2_timeout", timed_out, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check_quiet("midburst_reset");
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (5) @(negedge clock);
    check_eq("no_ready_after_reset", rdy_cnt - rd0, 0);
    check_eq("no_dirty_after_reset", dirty_cnt - dt0, 0);

    run_wb(6'h09, 3'd3, 44'h5A5, 128'h40, 2'b00, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
